// File: rtl/m2_seq_ctrl_if.sv
// Bus between the m2 sequencer and its surroundings: the job handshake with the core FSM
// and the control lines into the m2 header RAM, a..h register file, schedule and K-ROM.
interface m2_seq_ctrl_if;
  logic       start;
  logic       host_break;
  logic       m2_ticket2moon;
  logic [3:0] m2_header_ram_addr_a;
  logic [3:0] m2_header_ram_addr_b;
  logic       m2_header_ram_wren;
  logic       m2_abc_en;
  logic       m2_abc_load;
  logic       m2_wt_reg_en;
  logic       m2_wt_sw;
  logic [5:0] m2_k_rom_address;
  logic       m2_k_rom_clkh_en;
  logic       catch_bits;
  logic       busy;
  logic       done;
  logic       found;

  modport master (
    input  start, host_break, m2_ticket2moon,
    output m2_header_ram_addr_a, m2_header_ram_addr_b, m2_header_ram_wren,
           m2_abc_en, m2_abc_load, m2_wt_reg_en, m2_wt_sw,
           m2_k_rom_address, m2_k_rom_clkh_en,
           catch_bits, busy, done, found
  );

  modport slave (
    output start, host_break, m2_ticket2moon,
    input  m2_header_ram_addr_a, m2_header_ram_addr_b, m2_header_ram_wren,
           m2_abc_en, m2_abc_load, m2_wt_reg_en, m2_wt_sw,
           m2_k_rom_address, m2_k_rom_clkh_en,
           catch_bits, busy, done, found
  );
endinterface

// File: rtl/m2_seq_ctrl.sv
// Second-pass SHA-256 sequencer: writes the m1 digest into header RAM, primes a..h,
// steps the compression rounds, captures the result and samples the target compare.
module m2_seq_ctrl #(
  parameter int ROUNDS    = 64,
  parameter int HDR_WORDS = 16,
  parameter int WR_CYCLES = 4,
  parameter int CMP_LAT   = 2
) (
  input  logic         clk_h,
  input  logic         rst_n,
  m2_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, PRIME, ROUND, CATCH, WAIT, DONE} state_e;

  localparam logic [6:0] WR_LAST  = 7'(WR_CYCLES - 1);
  localparam logic [6:0] RND_LAST = 7'(ROUNDS - 1);
  localparam logic [6:0] CMP_LAST = 7'(CMP_LAT - 1);
  localparam logic [6:0] HDR_W    = 7'(HDR_WORDS);

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] nxt_round;

  logic [3:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [5:0] k_addr_q, k_addr_d;
  logic       wren_q, wren_d, abc_en_q, abc_en_d, abc_load_q, abc_load_d;
  logic       wt_en_q, wt_en_d, wt_sw_q, wt_sw_d, k_en_q, k_en_d;
  logic       catch_q, catch_d, busy_q, busy_d, done_q, done_d, found_q, found_d;

  // The counter restarts at every state change, so each phase counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 7'd1;
    found_d = found_q;
    if (state_q != IDLE && bus.host_break) begin
      state_d = IDLE;
      cnt_d   = '0;
      found_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.start && !bus.host_break) begin
            state_d = WRITE;
            found_d = 1'b0;
          end
        end
        WRITE: if (cnt_q == WR_LAST) begin state_d = PRIME; cnt_d = '0; end
        PRIME: begin state_d = ROUND; cnt_d = '0; end
        ROUND: if (cnt_q == RND_LAST) begin state_d = CATCH; cnt_d = '0; end
        CATCH: begin state_d = WAIT; cnt_d = '0; end
        WAIT: if (cnt_q == CMP_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          found_d = bus.m2_ticket2moon;
        end
        DONE:    begin state_d = IDLE; cnt_d = '0; end
        default: begin state_d = IDLE; cnt_d = '0; end
      endcase
    end
  end

  // Outputs are decoded from the state being entered so the registers line up with it.
  always_comb begin
    addr_a_d   = '0;
    addr_b_d   = '0;
    k_addr_d   = '0;
    wren_d     = 1'b0;
    abc_en_d   = 1'b0;
    abc_load_d = 1'b0;
    wt_en_d    = 1'b0;
    wt_sw_d    = 1'b0;
    k_en_d     = 1'b0;
    catch_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    nxt_round  = cnt_d + 7'd1;
    case (state_d)
      WRITE: begin
        wren_d   = 1'b1;
        addr_a_d = cnt_d[3:0];
        addr_b_d = 4'(cnt_d + 7'd4);
        busy_d   = 1'b1;
      end
      PRIME: begin
        abc_en_d   = 1'b1;
        abc_load_d = 1'b1;
        k_en_d     = 1'b1;
        busy_d     = 1'b1;
      end
      ROUND: begin
        abc_en_d = 1'b1;
        wt_en_d  = 1'b1;
        k_en_d   = 1'b1;
        busy_d   = 1'b1;
        wt_sw_d  = (cnt_d >= HDR_W);
        k_addr_d = nxt_round[5:0];
        addr_a_d = (nxt_round < HDR_W) ? nxt_round[3:0] : 4'd0;
      end
      CATCH: begin
        catch_d = 1'b1;
        busy_d  = 1'b1;
      end
      WAIT:    busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      k_addr_q   <= '0;
      wren_q     <= 1'b0;
      abc_en_q   <= 1'b0;
      abc_load_q <= 1'b0;
      wt_en_q    <= 1'b0;
      wt_sw_q    <= 1'b0;
      k_en_q     <= 1'b0;
      catch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      k_addr_q   <= k_addr_d;
      wren_q     <= wren_d;
      abc_en_q   <= abc_en_d;
      abc_load_q <= abc_load_d;
      wt_en_q    <= wt_en_d;
      wt_sw_q    <= wt_sw_d;
      k_en_q     <= k_en_d;
      catch_q    <= catch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
    end
  end

  assign bus.m2_header_ram_addr_a = addr_a_q;
  assign bus.m2_header_ram_addr_b = addr_b_q;
  assign bus.m2_header_ram_wren   = wren_q;
  assign bus.m2_abc_en            = abc_en_q;
  assign bus.m2_abc_load          = abc_load_q;
  assign bus.m2_wt_reg_en         = wt_en_q;
  assign bus.m2_wt_sw             = wt_sw_q;
  assign bus.m2_k_rom_address     = k_addr_q;
  assign bus.m2_k_rom_clkh_en     = k_en_q;
  assign bus.catch_bits           = catch_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.found                = found_q;

endmodule

// File: tb/tb_m2_seq_ctrl.sv
// Bench for m2_seq_ctrl: every cycle is compared against a timeline model that maps
// "cycles since the job was accepted" to the outputs expected in that cycle.
module tb_m2_seq_ctrl;

  localparam int LWR     = 4;
  localparam int LROUNDS = 64;
  localparam int LHDR    = 16;
  localparam int LCMP    = 2;
  localparam int TPRIME  = LWR + 1;
  localparam int TR0     = TPRIME + 1;
  localparam int TCATCH  = TR0 + LROUNDS;
  localparam int TDONE   = TCATCH + LCMP + 1;

  logic clk_h = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // Model state: mk = cycles since acceptance (0 = idle), mFound = expected found.
  int   mk = 0;
  logic mFound = 1'b0;

  m2_seq_ctrl_if bus ();

  m2_seq_ctrl dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_h = ~clk_h;

  logic [23:0] obs;
  assign obs = {bus.m2_header_ram_addr_a, bus.m2_header_ram_addr_b, bus.m2_header_ram_wren,
                bus.m2_abc_en, bus.m2_abc_load, bus.m2_wt_reg_en, bus.m2_wt_sw,
                bus.m2_k_rom_address, bus.m2_k_rom_clkh_en, bus.catch_bits,
                bus.busy, bus.done, bus.found};

  function automatic logic [23:0] expVec(input int k, input logic f);
    logic [3:0] a, b;
    logic [5:0] ka;
    logic wren, abcEn, abcLoad, wtEn, wtSw, kEn, catchB, busyB, doneB;
    int r;
    a = 0; b = 0; ka = 0;
    wren = 0; abcEn = 0; abcLoad = 0; wtEn = 0; wtSw = 0; kEn = 0;
    catchB = 0; busyB = 0; doneB = 0;
    if (k >= 1 && k <= LWR) begin
      a = 4'(k - 1); b = 4'(k - 1 + 4); wren = 1; busyB = 1;
    end else if (k == TPRIME) begin
      abcEn = 1; abcLoad = 1; kEn = 1; busyB = 1;
    end else if (k >= TR0 && k < TCATCH) begin
      r = k - TR0;
      abcEn = 1; wtEn = 1; kEn = 1; busyB = 1;
      wtSw = (r >= LHDR);
      ka = 6'((r + 1) % 64);
      a = (r + 1 < LHDR) ? 4'(r + 1) : 4'd0;
    end else if (k == TCATCH) begin
      catchB = 1; busyB = 1;
    end else if (k > TCATCH && k < TDONE) begin
      busyB = 1;
    end else if (k == TDONE) begin
      doneB = 1;
    end
    return {a, b, wren, abcEn, abcLoad, wtEn, wtSw, ka, kEn, catchB, busyB, doneB, f};
  endfunction

  // Drives one cycle of inputs, advances the model across the edge, settles for sampling.
  task automatic tick(input logic s, input logic b, input logic t);
    bus.start = s;
    bus.host_break = b;
    bus.m2_ticket2moon = t;
    @(posedge clk_h);
    if (mk == 0) begin
      if (s && !b) begin mk = 1; mFound = 1'b0; end
    end else if (b) begin
      mk = 0; mFound = 1'b0;
    end else if (mk == TDONE - 1) begin
      mFound = t; mk = TDONE;
    end else if (mk == TDONE) begin
      mk = 0;
    end else begin
      mk++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.host_break = 0; bus.m2_ticket2moon = 0;
    repeat (3) @(posedge clk_h);
    #1;
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("[TB] FAIL reset_outputs got=%h want=%h", obs, 24'h0);
    end
    @(negedge clk_h);
    rst_n = 1'b1;
    mk = 0; mFound = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1'($urandom_range(0, 1)));
      tests++;
      if (obs !== 24'h0 || bus.busy !== 1'b0) begin
        fails++; $display("[TB] FAIL idle_outputs cyc=%0d got=%h want=%h", i, obs, 24'h0);
      end
    end
  endtask

  task automatic test_full_job();
    int cycles;
    tick(1, 0, 1'($urandom_range(0, 1)));
    cycles = 1;
    tests++;
    if (obs !== expVec(mk, mFound)) begin
      fails++; $display("[TB] FAIL full_job k=%0d got=%h want=%h", mk, obs, expVec(mk, mFound));
    end
    while (bus.done !== 1'b1 && cycles < 200) begin
      tick(0, 0, 1'($urandom_range(0, 1)));
      cycles++;
      tests++;
      if (obs !== expVec(mk, mFound)) begin
        fails++; $display("[TB] FAIL full_job k=%0d got=%h want=%h", mk, obs, expVec(mk, mFound));
      end
    end
    tests++;
    if (cycles !== TDONE) begin
      fails++; $display("[TB] FAIL start_to_done got=%0d want=%0d", cycles, TDONE);
    end
    tick(0, 0, 0);
    tests++;
    if (obs !== expVec(mk, mFound)) begin
      fails++; $display("[TB] FAIL after_done got=%h want=%h", obs, expVec(mk, mFound));
    end
  endtask

  task automatic test_found();
    for (int job = 0; job < 2; job++) begin
      logic want;
      want = (job == 0);
      tick(1, 0, ~want);
      for (int i = 0; i < TDONE + 1; i++) begin
        tick(0, 0, (mk == TDONE - 1) ? want : ~want);
        tests++;
        if (obs !== expVec(mk, mFound)) begin
          fails++; $display("[TB] FAIL found_job%0d k=%0d got=%h want=%h", job, mk, obs, expVec(mk, mFound));
        end
        if (mk == TDONE) begin
          tests++;
          if (bus.found !== want || bus.done !== 1'b1) begin
            fails++; $display("[TB] FAIL found_at_done job%0d got=%b/%b want=%b/1", job, bus.found, bus.done, want);
          end
        end
      end
    end
  endtask

  task automatic test_break();
    tick(1, 0, 0);
    while (mk != TR0 + 30 && mk != 0) tick(0, 0, 1'($urandom_range(0, 1)));
    tests++;
    if (obs !== expVec(TR0 + 30, 1'b0)) begin
      fails++; $display("[TB] FAIL round30 got=%h want=%h", obs, expVec(TR0 + 30, 1'b0));
    end
    tick(0, 1, 0);
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("[TB] FAIL break_clear got=%h want=%h", obs, 24'h0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, i == 2, 1);
      tests++;
      if (obs !== 24'h0) begin
        fails++; $display("[TB] FAIL break_idle cyc=%0d got=%h want=%h", i, obs, 24'h0);
      end
    end
    tick(1, 1, 0);
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("[TB] FAIL break_beats_start got=%h want=%h", obs, 24'h0);
    end
    test_full_job();
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    for (int i = 0; i < 2 * (TDONE + 1) + 5; i++) begin
      tick(1, 0, 1'($urandom_range(0, 1)));
      if (bus.done === 1'b1) dones++;
      tests++;
      if (obs !== expVec(mk, mFound)) begin
        fails++; $display("[TB] FAIL b2b cyc=%0d k=%0d got=%h want=%h", i, mk, obs, expVec(mk, mFound));
      end
    end
    tests++;
    if (dones !== 2) begin
      fails++; $display("[TB] FAIL b2b_done_count got=%0d want=2", dones);
    end
    while (mk != 0) tick(0, 1, 0);
  endtask

  task automatic test_async_reset();
    tick(1, 0, 0);
    tick(0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("[TB] FAIL async_reset got=%h want=%h", obs, 24'h0);
    end
    @(posedge clk_h);
    @(negedge clk_h);
    rst_n = 1'b1;
    mk = 0; mFound = 0;
    test_full_job();
  endtask

  task automatic test_random();
    logic s, b;
    for (int i = 0; i < 2000; i++) begin
      s = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 149) == 0);
      tick(s, b, 1'($urandom_range(0, 1)));
      tests++;
      if (obs !== expVec(mk, mFound)) begin
        fails++; $display("[TB] FAIL random cyc=%0d k=%0d got=%h want=%h", i, mk, obs, expVec(mk, mFound));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_found();
    test_break();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

endmodule
